// File: rtl/ps_scan_pkg.sv
// Shared types and helpers for the MMCM phase eye-scan controller.
// State encodings, pass reduction and window centring.
package ps_scan_pkg;

  localparam int MAX_CH = 32;
  localparam int MAX_PW = 16;

  typedef enum logic [3:0] {
    IDLE,
    SC_EVAL,
    SC_STEP,
    SC_WAIT,
    SC_SETTLE,
    CT_STEP,
    CT_WAIT,
    MAN_STEP,
    MAN_WAIT,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    SU_IDLE,
    SU_WAIT,
    SU_SETTLE
  } step_t;

  // Unused upper mask bits are 0, so they count as passing.
  function automatic logic all_pass(
    input logic [MAX_CH-1:0] ok,
    input logic [MAX_CH-1:0] mask
  );
    return &(ok | ~mask);
  endfunction

  function automatic logic [MAX_PW-1:0] win_centre(
    input logic [MAX_PW-1:0] start,
    input logic [MAX_PW-1:0] len
  );
    return start + (len >> 1);
  endfunction

endpackage

// File: rtl/ps_eye_scan_ctrl_if.sv
// Manual phase command channel from the control unit.
// valid/ready handshake carrying direction and step count.
interface ps_eye_scan_ctrl_if #(
  parameter int CMD_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_inc;
  logic [CMD_W-1:0] cmd_steps;

  modport master (
    output cmd_valid, cmd_inc, cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_inc, cmd_steps,
    output cmd_ready
  );

endinterface

// File: rtl/ps_step_unit.sv
// One MMCM phase step: PSEN pulse, PSDONE wait, optional settle.
// PS_TIMEOUT_EN adds a PSDONE watchdog reported on tmo.
module ps_step_unit
  import ps_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 15,
  parameter int TMO_CYC    = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic dir,
  input  logic settle_en,
  input  logic abort,
  input  logic ps_done,
  output logic ps_en,
  output logic ps_incdec,
  output logic stepped,
  output logic settled,
  output logic tmo
);

  localparam int CNT_W = $clog2(SETTLE_CYC + TMO_CYC + 1);

  step_t            phase;
  logic [CNT_W-1:0] cnt;
  logic             settle_q;

  assign stepped = (phase == SU_WAIT) && ps_done;
  assign settled = (phase == SU_SETTLE) &&
                   (cnt == CNT_W'(SETTLE_CYC - 1));

`ifdef PS_TIMEOUT_EN
  assign tmo = (phase == SU_WAIT) && !ps_done &&
               (cnt == CNT_W'(TMO_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  // Pulse PSEN once per start, then track PSDONE and settle time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= SU_IDLE;
      cnt       <= '0;
      settle_q  <= 1'b0;
      ps_en     <= 1'b0;
      ps_incdec <= 1'b0;
    end else begin
      ps_en     <= start;
      ps_incdec <= start & dir;
      if (abort) begin
        phase <= SU_IDLE;
      end else begin
        unique case (phase)
          SU_IDLE: begin
            if (start) begin
              phase    <= SU_WAIT;
              cnt      <= '0;
              settle_q <= settle_en;
            end
          end
          SU_WAIT: begin
            if (ps_done) begin
              phase <= settle_q ? SU_SETTLE : SU_IDLE;
              cnt   <= '0;
            end
`ifdef PS_TIMEOUT_EN
            else if (tmo) begin
              phase <= SU_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end
          SU_SETTLE: begin
            if (settled) phase <= SU_IDLE;
            else         cnt   <= cnt + 1'b1;
          end
          default: phase <= SU_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps_eye_scan_ctrl.sv
// MMCM fine-phase eye scan: sweep, find widest pass window, centre.
// Also runs manual inc/dec commands. PS_TIMEOUT_EN enables watchdog.
module ps_eye_scan_ctrl
  import ps_scan_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int SCAN_STEPS = 64,
  parameter int POS_W      = 7,
  parameter int SETTLE_CYC = 15,
  parameter int CMD_W      = 4,
  parameter int TMO_CYC    = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mmcm_locked,
  input  logic             scan_start,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [NCH-1:0]   ch_ok,
  ps_eye_scan_ctrl_if.slave cmd,
  output logic             ps_en,
  output logic             ps_incdec,
  input  logic             ps_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [POS_W-1:0] win_start,
  output logic [POS_W-1:0] win_len,
  output logic [POS_W-1:0] pos
);

  state_t           state;
  logic [POS_W-1:0] run_start, run_len, tgt;
  logic [CMD_W-1:0] rem;
  logic             man_dir;

  logic             active, abort, accept, pass, better, last;
  logic [POS_W-1:0] run_len_n, run_start_n;
  logic [POS_W-1:0] best_len_n, best_start_n, tgt_n;
  logic             step_start, step_dir;
  logic             stepped, settled, tmo;

  assign active = (state != IDLE) && (state != FINISH);
  assign abort  = active && !mmcm_locked;
  assign busy   = (state != IDLE);
  assign done   = (state == FINISH);

  assign cmd.cmd_ready = (state == IDLE) && mmcm_locked && !scan_start;
  assign accept = cmd.cmd_valid && cmd.cmd_ready;

  assign pass = all_pass(MAX_CH'(ch_ok), MAX_CH'(ch_mask));
  assign run_len_n   = pass ? run_len + 1'b1 : '0;
  assign run_start_n = (pass && run_len == '0) ? pos : run_start;
  assign better       = run_len_n > win_len;
  assign best_len_n   = better ? run_len_n : win_len;
  assign best_start_n = better ? run_start_n : win_start;
  assign tgt_n = (best_len_n == '0) ? '0 :
    POS_W'(win_centre(MAX_PW'(best_start_n), MAX_PW'(best_len_n)));
  assign last = (pos == POS_W'(SCAN_STEPS - 1));

  assign step_start = mmcm_locked &&
    (state == SC_STEP || state == CT_STEP || state == MAN_STEP);
  assign step_dir = (state == SC_STEP) ||
    (state == MAN_STEP && man_dir);

  ps_step_unit #(
    .SETTLE_CYC (SETTLE_CYC),
    .TMO_CYC    (TMO_CYC)
  ) u_step (
    .clk       (clk),
    .rst       (rst),
    .start     (step_start),
    .dir       (step_dir),
    .settle_en (state == SC_STEP),
    .abort     (abort),
    .ps_done   (ps_done),
    .ps_en     (ps_en),
    .ps_incdec (ps_incdec),
    .stepped   (stepped),
    .settled   (settled),
    .tmo       (tmo)
  );

  // Sequencer: scan sweep, centring walk-back, manual steps, abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pos       <= '0;
      err       <= 1'b0;
      win_start <= '0;
      win_len   <= '0;
      run_start <= '0;
      run_len   <= '0;
      tgt       <= '0;
      rem       <= '0;
      man_dir   <= 1'b0;
    end else if (abort || tmo) begin
      state <= FINISH;
      err   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (scan_start && mmcm_locked) begin
            pos       <= '0;
            err       <= 1'b0;
            run_start <= '0;
            run_len   <= '0;
            win_start <= '0;
            win_len   <= '0;
            state     <= SC_EVAL;
          end else if (accept) begin
            err     <= 1'b0;
            rem     <= cmd.cmd_steps;
            man_dir <= cmd.cmd_inc;
            state   <= (cmd.cmd_steps == '0) ? FINISH : MAN_STEP;
          end
        end
        SC_EVAL: begin
          run_len   <= run_len_n;
          run_start <= run_start_n;
          win_len   <= best_len_n;
          win_start <= best_start_n;
          if (last) begin
            tgt   <= tgt_n;
            err   <= (best_len_n == '0);
            state <= (tgt_n == pos) ? FINISH : CT_STEP;
          end else begin
            state <= SC_STEP;
          end
        end
        SC_STEP: state <= SC_WAIT;
        SC_WAIT: begin
          if (stepped) begin
            pos   <= pos + 1'b1;
            state <= SC_SETTLE;
          end
        end
        SC_SETTLE: if (settled) state <= SC_EVAL;
        CT_STEP: state <= CT_WAIT;
        CT_WAIT: begin
          if (stepped) begin
            pos   <= pos - 1'b1;
            state <= (pos - 1'b1 == tgt) ? FINISH : CT_STEP;
          end
        end
        MAN_STEP: state <= MAN_WAIT;
        MAN_WAIT: begin
          if (stepped) begin
            pos   <= man_dir ? pos + 1'b1 : pos - 1'b1;
            rem   <= rem - 1'b1;
            state <= (rem == CMD_W'(1)) ? FINISH : MAN_STEP;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_eye_scan_ctrl.sv
// Bench for ps_eye_scan_ctrl: MMCM/channel model plus window reference.
// Directed cases followed by randomized scans and manual commands.
module tb_ps_eye_scan_ctrl;

  localparam int NCH   = 4;
  localparam int STEPS = 16;
  localparam int PW    = 5;
  localparam int SET   = 4;
  localparam int CW    = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           mmcm_locked;
  logic           scan_start;
  logic [NCH-1:0] ch_mask;
  logic [NCH-1:0] ch_ok;
  logic           ps_en, ps_incdec, ps_done;
  logic           busy, done, err;
  logic [PW-1:0]  win_start, win_len, pos;

  ps_eye_scan_ctrl_if #(.CMD_W(CW)) cmd_if ();

  ps_eye_scan_ctrl #(
    .NCH        (NCH),
    .SCAN_STEPS (STEPS),
    .POS_W      (PW),
    .SETTLE_CYC (SET),
    .CMD_W      (CW),
    .TMO_CYC    (1023)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mmcm_locked (mmcm_locked),
    .scan_start  (scan_start),
    .ch_mask     (ch_mask),
    .ch_ok       (ch_ok),
    .cmd         (cmd_if),
    .ps_en       (ps_en),
    .ps_incdec   (ps_incdec),
    .ps_done     (ps_done),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .win_start   (win_start),
    .win_len     (win_len),
    .pos         (pos)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] pat [32];
  logic [4:0] ph = '0;
  logic [4:0] ph_org = '0;
  logic [4:0] rel;
  assign rel   = ph - ph_org;
  assign ch_ok = pat[rel];

  int n_inc = 0, n_dec = 0, proto_err = 0;
  int done_cnt = 0, rdy_viol = 0;
  bit out_pend = 0;
  bit hold_done = 0;
  bit discard = 0;
  int hold_at = -1;
  int exp_pos = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // MMCM model: answers each PSEN with PSDONE 1..4 cycles later.
  initial begin : mmcm
    bit dir;
    int dly;
    ps_done = 1'b0;
    dir = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      ps_done = 1'b0;
      if (discard) begin
        out_pend = 0;
      end else if (ps_en) begin
        if (out_pend) proto_err++;
        out_pend = 1;
        dir = ps_incdec;
        dly = $urandom_range(1, 4);
        if (ps_incdec) n_inc++;
        else           n_dec++;
      end else if (out_pend && !hold_done && int'(rel) != hold_at) begin
        if (dly <= 1) begin
          ps_done = 1'b1;
          out_pend = 0;
          ph = dir ? ph + 5'd1 : ph - 5'd1;
        end else begin
          dly--;
        end
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy && cmd_if.cmd_ready) rdy_viol++;
    end
  end

  // Widest all-pass run over the scan positions, earliest on ties.
  task automatic ref_scan(input logic [3:0] msk, output int ws, output int wl);
    logic pv [STEPS];
    for (int p = 0; p < STEPS; p++) pv[p] = &(pat[p] | ~msk);
    ws = 0;
    wl = 0;
    for (int s = 0; s < STEPS; s++) begin
      int e;
      e = s;
      while (e < STEPS && pv[e]) e++;
      if (e - s > wl) begin
        ws = s;
        wl = e - s;
      end
    end
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "/busy_end"}, int'(busy), 0);
  endtask

  task automatic do_discard();
    @(negedge clk);
    discard = 1;
    @(negedge clk);
    discard = 0;
  endtask

  task automatic run_scan(input string nm, input bit collide, input bit repulse);
    int ws, wl, tg, i0, d0, c0;
    ref_scan(ch_mask, ws, wl);
    tg = (wl == 0) ? 0 : ws + wl / 2;
    @(negedge clk);
    i0 = n_inc;
    d0 = n_dec;
    c0 = done_cnt;
    ph_org = ph;
    scan_start = 1'b1;
    if (collide) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_inc   = 1'b1;
      cmd_if.cmd_steps = 4'd3;
      #1;
      chk({nm, "/collide_rdy"}, int'(cmd_if.cmd_ready), 0);
    end
    @(negedge clk);
    scan_start = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    if (repulse) begin
      repeat (20) @(negedge clk);
      scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
    end
    wait_idle(nm, 3000);
    repeat (3) @(negedge clk);
    chk({nm, "/win_start"}, int'(win_start), ws);
    chk({nm, "/win_len"}, int'(win_len), wl);
    chk({nm, "/pos"}, int'(pos), tg);
    chk({nm, "/err"}, int'(err), int'(wl == 0));
    chk({nm, "/inc"}, n_inc - i0, STEPS - 1);
    chk({nm, "/dec"}, n_dec - d0, STEPS - 1 - tg);
    chk({nm, "/done"}, done_cnt - c0, 1);
    exp_pos = tg;
  endtask

  task automatic run_cmd(input string nm, input bit inc, input int steps);
    int i0, d0, c0;
    @(negedge clk);
    i0 = n_inc;
    d0 = n_dec;
    c0 = done_cnt;
    chk({nm, "/rdy"}, int'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_inc   = inc;
    cmd_if.cmd_steps = CW'(steps);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    wait_idle(nm, 500);
    repeat (2) @(negedge clk);
    exp_pos = (exp_pos + (inc ? steps : -steps)) & 31;
    chk({nm, "/pos"}, int'(pos), exp_pos);
    chk({nm, "/err"}, int'(err), 0);
    chk({nm, "/done"}, done_cnt - c0, 1);
    chk({nm, "/inc"}, n_inc - i0, inc ? steps : 0);
    chk({nm, "/dec"}, n_dec - d0, inc ? 0 : steps);
  endtask

  task automatic set_win(input int lo, input int hi);
    for (int p = 0; p < 32; p++)
      pat[p] = (p >= lo && p <= hi) ? 4'hF : 4'h0;
  endtask

  task automatic gen_rand();
    int lo, ln;
    ch_mask = 4'($urandom_range(0, 15));
    lo = $urandom_range(0, 15);
    ln = $urandom_range(0, 9);
    for (int p = 0; p < 32; p++)
      for (int c = 0; c < NCH; c++)
        pat[p][c] = (p >= lo && p < lo + ln) || ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 1) == 1) begin
      lo = $urandom_range(0, 15);
      ln = $urandom_range(1, 6);
      for (int p = lo; p < lo + ln && p < 32; p++) pat[p] = 4'hF;
    end
  endtask

  initial begin : main
    int n, t0;
    rst = 1'b1;
    mmcm_locked = 1'b0;
    scan_start = 1'b0;
    ch_mask = 4'hF;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_inc   = 1'b0;
    cmd_if.cmd_steps = '0;
    set_win(5, 10);
    repeat (4) @(negedge clk);
    chk("rst/busy", int'(busy), 0);
    chk("rst/done", int'(done), 0);
    chk("rst/err", int'(err), 0);
    chk("rst/pos", int'(pos), 0);
    chk("rst/win", int'({win_start, win_len}), 0);
    chk("rst/ps_en", int'(ps_en), 0);
    chk("rst/rdy", int'(cmd_if.cmd_ready), 0);
    rst = 1'b0;
    mmcm_locked = 1'b1;
    @(negedge clk);
    chk("idle/rdy", int'(cmd_if.cmd_ready), 1);

    ch_mask = 4'hF;
    set_win(5, 10);
    run_scan("win5_10", 0, 0);
    for (int p = 0; p < 32; p++)
      pat[p] = ((p >= 2 && p <= 4) || (p >= 9 && p <= 11)) ? 4'hF : 4'h0;
    run_scan("tie", 0, 0);
    set_win(40, 40);
    run_scan("nowin", 0, 0);
    ch_mask = 4'h7;
    for (int p = 0; p < 32; p++) pat[p] = 4'h7;
    run_scan("stuck3", 0, 0);
    run_cmd("man_inc3", 1, 3);
    run_cmd("man_dec12", 0, 12);
    run_cmd("man_zero", 1, 0);

    ch_mask = 4'hF;
    set_win(0, 15);
    hold_at = 6;
    @(negedge clk);
    ph_org = ph;
    t0 = done_cnt;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    n = 0;
    while (!(out_pend && rel == 5'd6) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("lock/reach6", int'(out_pend && rel == 5'd6), 1);
    mmcm_locked = 1'b0;
    wait_idle("lock", 50);
    repeat (2) @(negedge clk);
    chk("lock/err", int'(err), 1);
    chk("lock/pos", int'(pos), 6);
    chk("lock/done", done_cnt - t0, 1);
    chk("lock/rdy", int'(cmd_if.cmd_ready), 0);
    n = n_inc + n_dec;
    repeat (30) @(negedge clk);
    chk("lock/no_psen", n_inc + n_dec, n);
    do_discard();
    hold_at = -1;
    mmcm_locked = 1'b1;
    exp_pos = 6;

    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    n = 0;
    while (!out_pend && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = n_inc + n_dec;
    t0 = done_cnt;
    repeat (12) @(negedge clk);
    chk("mid_rst/pos", int'(pos), 0);
    chk("mid_rst/busy", int'(busy), 0);
    chk("mid_rst/err", int'(err), 0);
    chk("mid_rst/win_len", int'(win_len), 0);
    chk("mid_rst/done", done_cnt - t0, 0);
    chk("mid_rst/no_psen", n_inc + n_dec, n);
    chk("mid_rst/rdy", int'(cmd_if.cmd_ready), 1);
    do_discard();
    exp_pos = 0;

    for (int k = 0; k < 8; k++) begin
      gen_rand();
      run_scan($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0);
      run_cmd($sformatf("rcmd%0d", k), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15));
    end

`ifdef PS_TIMEOUT_EN
    hold_done = 1;
    @(negedge clk);
    t0 = done_cnt;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    wait_idle("tmo", 3000);
    repeat (2) @(negedge clk);
    chk("tmo/err", int'(err), 1);
    chk("tmo/pos", int'(pos), 0);
    chk("tmo/done", done_cnt - t0, 1);
    do_discard();
    hold_done = 0;
`endif

    chk("proto/psen_overlap", proto_err, 0);
    chk("proto/rdy_busy", rdy_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
